// File: rtl/voice_flap_detector_pkg.sv
// ---------------------------------------------------------------------------
// voice_pkg
//   Shared definitions for the voice flap detector and the flap-timing counter.
//   - DEFAULT_DATA_W / DEFAULT_WIN_LOG2 : default sample width and window size
//   - vfd_state_t                       : detector FSM states
//   - abs_sat()                         : saturating magnitude of a signed sample
// ---------------------------------------------------------------------------
package voice_pkg;

  localparam int DEFAULT_DATA_W   = 24;
  localparam int DEFAULT_WIN_LOG2 = 5;

  // abs_sat works on a wide carrier so one function serves every sample width.
  localparam int ABS_W = 64;

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLDOFF} vfd_state_t;

  // |s| for a sample of width w, sign-extended to ABS_W bits by the caller.
  // The most negative value -2^(w-1) has no positive counterpart in w-1 bits,
  // so it saturates to 2^(w-1)-1.
  function automatic logic [ABS_W-1:0] abs_sat(input logic signed [ABS_W-1:0] s,
                                               input int unsigned             w);
    logic signed [ABS_W-1:0] most_neg;
    most_neg = {ABS_W{1'b1}} << (w - 1);
    if (s == most_neg) return ~most_neg;
    if (s < 0)         return -s;
    return s;
  endfunction

endpackage

// File: rtl/voice_flap_detector_if.sv
// ---------------------------------------------------------------------------
// voice_flap_detector_if
//   Sample stream, thresholds and detector results.
//   master : codec/control side (drives samples and thresholds)
//   slave  : voice_flap_detector
// ---------------------------------------------------------------------------
interface voice_flap_detector_if
  import voice_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int WIN_LOG2 = DEFAULT_WIN_LOG2,
  parameter int EN_W     = DATA_W - 1 + WIN_LOG2
);
  logic                     sample_valid;
  logic signed [DATA_W-1:0] sample;
  logic [EN_W-1:0]          thresh_on;
  logic [EN_W-1:0]          thresh_off;
  logic [EN_W-1:0]          energy;
  logic                     energy_valid;
  logic                     voice_active;
  logic                     flap;

  modport master (
    output sample_valid, sample, thresh_on, thresh_off,
    input  energy, energy_valid, voice_active, flap
  );

  modport slave (
    input  sample_valid, sample, thresh_on, thresh_off,
    output energy, energy_valid, voice_active, flap
  );
endinterface

// File: rtl/voice_flap_detector_window_energy.sv
// ---------------------------------------------------------------------------
// window_energy
//   Sums |sample| over windows of 2^WIN_LOG2 accepted samples.
//   clk, reset         : clock, synchronous active-high reset
//   sample_valid/sample: sample accepted on every edge where sample_valid=1
//   energy             : sum of the last completed window
//   energy_valid       : one-cycle pulse when energy updates
// ---------------------------------------------------------------------------
module window_energy
  import voice_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int WIN_LOG2 = DEFAULT_WIN_LOG2,
  parameter int EN_W     = DATA_W - 1 + WIN_LOG2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample,
  output logic [EN_W-1:0]          energy,
  output logic                     energy_valid
);

  logic [DATA_W-2:0]   mag;
  logic [EN_W-1:0]     acc;
  logic [EN_W-1:0]     acc_next;
  logic [WIN_LOG2-1:0] cnt;

  assign mag      = (DATA_W-1)'(abs_sat(ABS_W'(sample), DATA_W));
  assign acc_next = acc + EN_W'(mag);

  // NOTE: sequential state is written with <= only, so every register in this
  // block sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      cnt          <= '0;
      energy       <= '0;
      energy_valid <= 1'b0;
    end else begin
      energy_valid <= 1'b0;
      if (sample_valid) begin
        // Last sample of the window: publish the total and start a fresh one.
        if (&cnt) begin
          energy       <= acc_next;
          energy_valid <= 1'b1;
          acc          <= '0;
        end else begin
          acc <= acc_next;
        end
        cnt <= cnt + 1'b1;  // wraps to 0 after the last sample
      end
    end
  end

endmodule

// File: rtl/voice_flap_detector.sv
// ---------------------------------------------------------------------------
// voice_flap_detector
//   Window energy followed by an IDLE/ACTIVE/HOLDOFF hysteresis FSM.
//   clk, reset : clock, synchronous active-high reset
//   bus        : sample stream and thresholds in; energy, energy_valid,
//                voice_active (level) and flap (1-cycle pulse) out
// ---------------------------------------------------------------------------
module voice_flap_detector
  import voice_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int WIN_LOG2    = DEFAULT_WIN_LOG2,
  parameter int HOLDOFF_WIN = 4,
  parameter int EN_W        = DATA_W - 1 + WIN_LOG2
) (
  input logic                  clk,
  input logic                  reset,
  voice_flap_detector_if.slave bus
);

  localparam int HC_W = $clog2(HOLDOFF_WIN + 1);

  logic [EN_W-1:0] energy;
  logic            energy_valid;
  vfd_state_t      state;
  logic [HC_W-1:0] hold_cnt;
  logic            voice_active_q;
  logic            flap_q;

  window_energy #(
    .DATA_W   (DATA_W),
    .WIN_LOG2 (WIN_LOG2),
    .EN_W     (EN_W)
  ) u_window_energy (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (bus.sample_valid),
    .sample       (bus.sample),
    .energy       (energy),
    .energy_valid (energy_valid)
  );

  // The FSM only moves when a window completes; between windows it holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      voice_active_q <= 1'b0;
      flap_q         <= 1'b0;
    end else begin
      flap_q <= 1'b0;
      if (energy_valid) begin
        case (state)
          IDLE: begin
            if (energy >= bus.thresh_on) begin
              state          <= ACTIVE;
              voice_active_q <= 1'b1;
              flap_q         <= 1'b1;
            end
          end
          ACTIVE: begin
            if (energy < bus.thresh_off) begin
              state          <= HOLDOFF;
              voice_active_q <= 1'b0;
              hold_cnt       <= HC_W'(HOLDOFF_WIN);
            end
          end
          HOLDOFF: begin
            // Energy is ignored here so loud windows cannot retrigger a flap.
            if (hold_cnt == HC_W'(1)) state <= IDLE;
            hold_cnt <= hold_cnt - 1'b1;
          end
          default: begin
            state          <= IDLE;
            voice_active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.energy       = energy;
  assign bus.energy_valid = energy_valid;
  assign bus.voice_active = voice_active_q;
  assign bus.flap         = flap_q;

endmodule

// File: tb/tb_voice_flap_detector.sv
// ---------------------------------------------------------------------------
// tb_voice_flap_detector
//   Directed window table, a reset-mid-window sequence and a randomized run,
//   all compared cycle by cycle against a behavioural model of the detector.
// ---------------------------------------------------------------------------
module tb_voice_flap_detector;

  localparam int DATA_W   = 24;
  localparam int WIN_LOG2 = 5;
  localparam int EN_W     = 28;
  localparam int WIN_LEN  = 32;
  localparam int HOLD_WIN = 4;

  logic clk = 1'b0;
  logic reset;

  voice_flap_detector_if #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2), .EN_W(EN_W)) bus ();

  voice_flap_detector #(
    .DATA_W      (DATA_W),
    .WIN_LOG2    (WIN_LOG2),
    .HOLDOFF_WIN (HOLD_WIN),
    .EN_W        (EN_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Window: list of magnitudes collected so far. Detector: "active" flag plus
  // number of quiet-out windows still to wait; idle means neither.
  longint win_mags[$];
  longint m_energy;
  bit     m_ev;
  bit     m_active;
  bit     m_flap;
  int     m_hold_left;

  function automatic longint ref_mag(input longint s);
    longint m;
    m = (s < 0) ? -s : s;
    if (m > 8388607) m = 8388607;
    return m;
  endfunction

  task automatic model_edge();
    longint sum;
    if (reset) begin
      win_mags.delete();
      m_energy = 0; m_ev = 0; m_active = 0; m_flap = 0; m_hold_left = 0;
      return;
    end
    m_flap = 0;
    if (m_ev) begin
      if (m_active) begin
        if (m_energy < longint'(bus.thresh_off)) begin
          m_active    = 0;
          m_hold_left = HOLD_WIN;
        end
      end else if (m_hold_left > 0) begin
        m_hold_left--;
      end else if (m_energy >= longint'(bus.thresh_on)) begin
        m_active = 1;
        m_flap   = 1;
      end
    end
    m_ev = 0;
    if (bus.sample_valid) begin
      win_mags.push_back(ref_mag(longint'(bus.sample)));
      if (win_mags.size() == WIN_LEN) begin
        sum = 0;
        foreach (win_mags[i]) sum += win_mags[i];
        m_energy = sum;
        m_ev     = 1;
        win_mags.delete();
      end
    end
  endtask

  // One clock: drive on the falling edge, model the rising edge, compare 1ns later.
  task automatic step(input bit v, input int s, input bit rst);
    @(negedge clk);
    bus.sample_valid = v;
    bus.sample       = DATA_W'(s);
    reset            = rst;
    @(posedge clk);
    model_edge();
    #1;
    check("model_energy",       64'(bus.energy),       64'(m_energy));
    check("model_energy_valid", 64'(bus.energy_valid), 64'(m_ev));
    check("model_voice_active", 64'(bus.voice_active), 64'(m_active));
    check("model_flap",         64'(bus.flap),         64'(m_flap));
  endtask

  // ---------------- directed window table ----------------
  typedef struct {
    string  name;
    int     amp;        // amplitude of samples 0..30
    int     last_amp;   // amplitude of sample 31
    bit     alt;        // odd samples negated
    bit     gaps;       // one idle cycle between samples
    longint exp_energy;
    bit     exp_flap;
    bit     exp_active;
  } vec_t;

  vec_t vecs[$];

  task automatic run_window(input vec_t v);
    int s;
    for (int i = 0; i < WIN_LEN; i++) begin
      s = (i == WIN_LEN - 1) ? v.last_amp : v.amp;
      if (v.alt && i[0]) s = -s;
      if (v.gaps && i != 0) step(1'b0, 0, 1'b0);
      step(1'b1, s, 1'b0);
    end
    check({v.name, "_energy_valid"}, 64'(bus.energy_valid), 64'd1);
    check({v.name, "_energy"},       64'(bus.energy),       64'(v.exp_energy));
    step(1'b0, 0, 1'b0);
    check({v.name, "_flap"},         64'(bus.flap),         64'(v.exp_flap));
    check({v.name, "_voice_active"}, 64'(bus.voice_active), 64'(v.exp_active));
    step(1'b0, 0, 1'b0);
    check({v.name, "_flap_cleared"}, 64'(bus.flap),         64'd0);
  endtask

  initial begin
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample       = '0;
    bus.thresh_on    = EN_W'(20000);
    bus.thresh_off   = EN_W'(10000);
    win_mags.delete();
    m_energy = 0; m_ev = 0; m_active = 0; m_flap = 0; m_hold_left = 0;

    vecs.push_back('{"loud_from_idle", 1000, 1000, 1'b0, 1'b0, 32000, 1'b1, 1'b1});
    vecs.push_back('{"hyst_400",        400,  400, 1'b1, 1'b0, 12800, 1'b0, 1'b1});
    vecs.push_back('{"quiet_200",       200,  200, 1'b1, 1'b0,  6400, 1'b0, 1'b0});
    vecs.push_back('{"holdoff_1",      1000, 1000, 1'b0, 1'b0, 32000, 1'b0, 1'b0});
    vecs.push_back('{"holdoff_2",      1000, 1000, 1'b0, 1'b0, 32000, 1'b0, 1'b0});
    vecs.push_back('{"holdoff_3",      1000, 1000, 1'b0, 1'b0, 32000, 1'b0, 1'b0});
    vecs.push_back('{"holdoff_4",      1000, 1000, 1'b0, 1'b0, 32000, 1'b0, 1'b0});
    vecs.push_back('{"reflap",         1000, 1000, 1'b0, 1'b0, 32000, 1'b1, 1'b1});
    vecs.push_back('{"silence_exit",      0,    0, 1'b0, 1'b0,     0, 1'b0, 1'b0});
    for (int k = 0; k < HOLD_WIN; k++)
      vecs.push_back('{"silence_hold",    0,    0, 1'b0, 1'b0,     0, 1'b0, 1'b0});
    vecs.push_back('{"saturate_gaps", -8388608, -8388608, 1'b0, 1'b1, 268435424, 1'b1, 1'b1});
    vecs.push_back('{"silence_exit2",     0,    0, 1'b0, 1'b0,     0, 1'b0, 1'b0});
    for (int k = 0; k < HOLD_WIN; k++)
      vecs.push_back('{"silence_hold2",   0,    0, 1'b0, 1'b0,     0, 1'b0, 1'b0});
    vecs.push_back('{"edge_19999",      625,  624, 1'b0, 1'b0, 19999, 1'b0, 1'b0});
    vecs.push_back('{"edge_20000",      625,  625, 1'b0, 1'b0, 20000, 1'b1, 1'b1});

    // Reset state.
    step(1'b1, 1000, 1'b1);
    step(1'b1, 1000, 1'b1);
    check("reset_energy",       64'(bus.energy),       64'd0);
    check("reset_energy_valid", 64'(bus.energy_valid), 64'd0);
    check("reset_voice_active", 64'(bus.voice_active), 64'd0);
    check("reset_flap",         64'(bus.flap),         64'd0);

    foreach (vecs[i]) run_window(vecs[i]);

    // Reset mid-window: 20 loud samples are discarded.
    for (int i = 0; i < 20; i++) step(1'b1, 1000, 1'b0);
    step(1'b1, 1000, 1'b1);
    check("midreset_energy",       64'(bus.energy),       64'd0);
    check("midreset_energy_valid", 64'(bus.energy_valid), 64'd0);
    check("midreset_voice_active", 64'(bus.voice_active), 64'd0);
    check("midreset_flap",         64'(bus.flap),         64'd0);
    for (int i = 0; i < WIN_LEN; i++) step(1'b1, 100, 1'b0);
    check("after_reset_energy",       64'(bus.energy),       64'd3200);
    check("after_reset_energy_valid", 64'(bus.energy_valid), 64'd1);
    step(1'b0, 0, 1'b0);
    check("after_reset_flap",         64'(bus.flap),         64'd0);
    check("after_reset_voice_active", 64'(bus.voice_active), 64'd0);

    // Randomized run; second half uses thresh_off > thresh_on.
    for (int c = 0; c < 6000; c++) begin
      int  s;
      bit  v;
      bit  r;
      if (c == 3000) begin
        bus.thresh_on  = EN_W'(12000);
        bus.thresh_off = EN_W'(25000);
      end
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 3) s = -8388608;
      else begin
        s = int'($urandom_range(0, 1300));
        if ($urandom_range(0, 1) == 1) s = -s;
      end
      r = ($urandom_range(0, 799) == 0);
      step(v, s, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
